// File: rtl/uart_pkg.sv
// Shared constants and types for the 8N1 UART command transmitter.
// Frame geometry, default divisor and the transmitter state type live here.
package uart_pkg;

    localparam int unsigned BITS_PER_FRAME   = 10;
    localparam int unsigned BYTES_PER_CMD    = 3;
    localparam int unsigned DEFAULT_BAUD_DIV = 2604;

    typedef enum logic {
        IDLE,
        XMIT
    } tx_state_e;

endpackage

// File: rtl/uart_byte_ser.sv
// Single 8N1 frame serializer: baud counter, bit counter and 10-bit shift register.
// TX is bit 0 of the shift register, so the line is always driven straight from a flop.
module uart_byte_ser
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       TX,
    output logic       frame_done
);

    localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  BitLast  = 4'(BITS_PER_FRAME - 1);

    logic        active_q, active_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  shreg_q, shreg_d;
    logic        baud_tick;

    assign baud_tick  = active_q && (baud_cnt_q == BaudLast);
    assign frame_done = baud_tick && (bit_cnt_q == BitLast);
    assign TX         = shreg_q[0];

    always_comb begin
        active_d   = active_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        if (load) begin
            // Start bit goes out immediately; stop bit rides in at the top.
            active_d   = 1'b1;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shreg_d    = {1'b1, byte_in, 1'b0};
        end else if (active_q) begin
            if (baud_tick) begin
                baud_cnt_d = '0;
                if (bit_cnt_q == BitLast) begin
                    active_d  = 1'b0;
                    bit_cnt_d = '0;
                    shreg_d   = '1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    shreg_d   = {1'b1, shreg_q[9:1]};
                end
            end else begin
                baud_cnt_d = baud_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '1;
        end else begin
            active_q   <= active_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// Sends a 24-bit command as three back-to-back 8N1 frames, high byte first.
// cmd_sent is a sticky done flag cleared by the next accepted request.
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [23:0] cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);

    localparam logic [1:0] ByteLast = 2'(BYTES_PER_CMD - 1);

    tx_state_e   state_q, state_d;
    logic [23:0] shadow_q, shadow_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        cmd_sent_q, cmd_sent_d;
    logic        accept, last_byte, load, frame_done;
    logic [7:0]  byte_in;

    assign accept    = (state_q == IDLE) && snd_cmd;
    assign last_byte = (byte_idx_q == ByteLast);
    assign cmd_sent  = cmd_sent_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (snd_cmd) state_d = XMIT;
            XMIT:    if (frame_done && last_byte) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The first byte bypasses the shadow register since it is loaded on the same edge.
    always_comb begin
        busy    = (state_q == XMIT);
        load    = accept || ((state_q == XMIT) && frame_done && !last_byte);
        byte_in = cmd[23:16];
        if (state_q == XMIT) begin
            byte_in = (byte_idx_q == 2'd0) ? shadow_q[15:8] : shadow_q[7:0];
        end
    end

    always_comb begin
        shadow_d   = shadow_q;
        byte_idx_d = byte_idx_q;
        cmd_sent_d = cmd_sent_q;
        if (accept) begin
            shadow_d   = cmd;
            byte_idx_d = '0;
            cmd_sent_d = 1'b0;
        end else if ((state_q == XMIT) && frame_done) begin
            if (last_byte) begin
                byte_idx_d = '0;
                cmd_sent_d = 1'b1;
            end else begin
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q   <= '0;
            byte_idx_q <= '0;
            cmd_sent_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            byte_idx_q <= byte_idx_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end

    uart_byte_ser #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .byte_in   (byte_in),
        .TX        (TX),
        .frame_done(frame_done)
    );

endmodule
